// File: rtl/d_cache_write_buffer_pkg.sv
// Shared types and constants for the data-cache posted-write buffer.
// Holds the FSM state encoding and the packed FIFO entry layout.
package d_cache_write_buffer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_W_REQ  = 3'd1;
  localparam logic [2:0] S_W_WAIT = 3'd2;
  localparam logic [2:0] S_R_REQ  = 3'd3;
  localparam logic [2:0] S_R_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    W_REQ  = S_W_REQ,
    W_WAIT = S_W_WAIT,
    R_REQ  = S_R_REQ,
    R_WAIT = S_R_WAIT
  } state_e;

  // Entry layout: {addr[31:0], size[1:0], wdata[31:0]}
  localparam int ENTRY_W   = 32 + 32 + 2;
  localparam int WDATA_LSB = 0;
  localparam int SIZE_LSB  = 32;
  localparam int ADDR_LSB  = 34;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    return {addr, size, wdata};
  endfunction

endpackage

// File: rtl/d_cache_write_buffer_wb_fifo.sv
// Write-buffer FIFO: DEPTH x ENTRY_W storage, push at tail, pop at head.
// Ports: push_i/pop_i/din_i in; head_o, full_o, empty_o, count_o out.
module wb_fifo
  import d_cache_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] din_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [PTR_W:0]     count_o
);

  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth: pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PTR_ONE;
    if (do_pop)  head_d = head_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din_i;
  end

endmodule

// File: rtl/d_cache_write_buffer.sv
// Posted-write buffer between the D-cache memory port and the AXI sram port.
// Ports: in_* upstream sram-like slave side, out_* downstream master side.
module d_cache_write_buffer
  import d_cache_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  input  logic        in_wr,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic [31:0] in_rdata,
  output logic        in_addr_ok,
  output logic        in_data_ok,
  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic [31:0] out_rdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok
);

  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  state_e             state_q, state_d;
  logic [31:0]        rd_addr_q, rd_addr_d;
  logic [1:0]         rd_size_q, rd_size_d;
  logic               wr_ok_q;

  logic               full, empty;
  logic [PTR_W:0]     count;
  logic [ENTRY_W-1:0] head;

  logic               wr_acc, rd_acc, pop, rd_done;

  // Writes stall only while a read owns the downstream port.
  assign wr_acc = in_req & in_wr & ~full &
                  (state_q != R_REQ) & (state_q != R_WAIT);
  // Reads wait for a fully drained buffer to keep RAW order.
  assign rd_acc = in_req & ~in_wr & empty & (state_q == IDLE);

  assign in_addr_ok = ~rst & (wr_acc | rd_acc);
  assign pop        = (state_q == W_WAIT) & out_data_ok;
  assign rd_done    = (state_q == R_WAIT) & out_data_ok;
  assign in_data_ok = wr_ok_q | rd_done;
  assign in_rdata   = out_rdata;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_acc),
    .pop_i   (pop),
    .din_i   (pack_entry(in_addr, in_size, in_wdata)),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;
    if (rd_acc) begin
      rd_addr_d = in_addr;
      rd_size_d = in_size;
    end
    unique case (state_q)
      IDLE: begin
        if (!empty)      state_d = W_REQ;
        else if (rd_acc) state_d = R_REQ;
      end
      W_REQ: begin
        if (out_addr_ok) state_d = W_WAIT;
      end
      W_WAIT: begin
        // A same-edge push keeps the drain going.
        if (pop) begin
          if ((count > CNT_ONE) || wr_acc) state_d = W_REQ;
          else                             state_d = IDLE;
        end
      end
      R_REQ: begin
        if (out_addr_ok) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (rd_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream fields come from the FIFO head or the read latch;
  // both hold steady for as long as the request is up.
  always_comb begin
    out_req   = 1'b0;
    out_wr    = 1'b0;
    out_size  = '0;
    out_addr  = '0;
    out_wdata = '0;
    unique case (state_q)
      W_REQ: begin
        out_req   = 1'b1;
        out_wr    = 1'b1;
        out_addr  = head[ADDR_LSB +: 32];
        out_size  = head[SIZE_LSB +: 2];
        out_wdata = head[WDATA_LSB +: 32];
      end
      R_REQ: begin
        out_req  = 1'b1;
        out_addr = rd_addr_q;
        out_size = rd_size_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_size_q <= '0;
      wr_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_size_q <= rd_size_d;
      wr_ok_q   <= wr_acc;
    end
  end

endmodule

// File: tb/tb_d_cache_write_buffer.sv
// Directed bench for d_cache_write_buffer.
// Drives upstream, models downstream memory, checks with assertions.
module tb_d_cache_write_buffer;
  import d_cache_write_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_req, in_wr;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_rdata;
  logic        in_addr_ok, in_data_ok;
  logic        out_req, out_wr;
  logic [1:0]  out_size;
  logic [31:0] out_addr, out_wdata, out_rdata;
  logic        out_addr_ok, out_data_ok;

  logic        ra_addr_ok, ra_data_ok;
  logic        ma_addr_ok, ma_data_ok;
  assign out_addr_ok = ra_addr_ok | ma_addr_ok;
  assign out_data_ok = ra_data_ok | ma_data_ok;

  int tests = 0;
  int fails = 0;

  logic        auto_en;
  int          dly_max;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic        log_wr [$];

  d_cache_write_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_req      (in_req),
    .in_wr       (in_wr),
    .in_size     (in_size),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .in_rdata    (in_rdata),
    .in_addr_ok  (in_addr_ok),
    .in_data_ok  (in_data_ok),
    .out_req     (out_req),
    .out_wr      (out_wr),
    .out_size    (out_size),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .out_rdata   (out_rdata),
    .out_addr_ok (out_addr_ok),
    .out_data_ok (out_data_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Downstream memory model with optional random handshake delays.
  initial begin : responder
    int          phase;
    int          cnt;
    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    phase = 0;
    cnt = 0;
    ra_addr_ok = 1'b0;
    ra_data_ok = 1'b0;
    out_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      ra_addr_ok = 1'b0;
      ra_data_ok = 1'b0;
      if (rst) begin
        phase = 0;
        cnt = 0;
      end else if (phase == 0) begin
        if (auto_en && out_req) begin
          if (cnt > 0) cnt--;
          else begin
            ra_addr_ok = 1'b1;
            cur_wr = out_wr;
            cur_addr = out_addr;
            cur_wdata = out_wdata;
            log_addr.push_back(out_addr);
            log_wr.push_back(out_wr);
            cnt = int'($urandom_range(dly_max, 0));
            phase = 1;
          end
        end
      end else begin
        if (cnt > 0) cnt--;
        else begin
          ra_data_ok = 1'b1;
          if (cur_wr) mem[cur_addr] = cur_wdata;
          else out_rdata = mem.exists(cur_addr) ? mem[cur_addr] : '0;
          cnt = int'($urandom_range(dly_max, 0));
          phase = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input int lim, output int waited, output logic ok);
    in_req = 1'b1;
    in_wr = 1'b1;
    in_size = 2'd2;
    in_addr = a;
    in_wdata = d;
    waited = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (in_addr_ok) begin
        ok = 1'b1;
        break;
      end
      waited++;
      if (waited >= lim) break;
    end
    @(posedge clk);
    #1;
    in_req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input int lim,
                    output int waited, output logic emp_at_acc,
                    output logic [31:0] data, output logic ok);
    int n;
    in_req = 1'b1;
    in_wr = 1'b0;
    in_size = 2'd2;
    in_addr = a;
    waited = 0;
    ok = 1'b0;
    emp_at_acc = 1'b0;
    data = '0;
    forever begin
      @(negedge clk);
      if (in_addr_ok) begin
        ok = 1'b1;
        emp_at_acc = dut.u_fifo.empty_o;
        break;
      end
      waited++;
      if (waited >= lim) break;
    end
    @(posedge clk);
    #1;
    in_req = 1'b0;
    if (ok) begin
      ok = 1'b0;
      n = 0;
      while (n < lim) begin
        @(negedge clk);
        if (in_data_ok) begin
          ok = 1'b1;
          data = in_rdata;
          break;
        end
        n++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int lim, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (dut.state_q == S_IDLE && dut.u_fifo.empty_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int          w;
    logic        ok;
    logic        emp;
    logic [31:0] rdv;

    rst = 1'b1;
    in_req = 1'b1;
    in_wr = 1'b1;
    in_size = '0;
    in_addr = 32'h0;
    in_wdata = '0;
    auto_en = 1'b0;
    dly_max = 0;
    ma_addr_ok = 1'b0;
    ma_data_ok = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_in_data_ok", 64'(in_data_ok), 64'd0);
    chk("rst_in_addr_ok", 64'(in_addr_ok), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count_o), 64'd0);
    in_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single write, 1-cycle ack, then downstream request
    wr(32'h1000_0040, 32'hDEAD_BEEF, 10, w, ok);
    chk("t1_aok", 64'(ok), 64'd1);
    chk("t1_aok_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_dok_c1", 64'(in_data_ok), 64'd1);
    chk("t1_req_c1", 64'(out_req), 64'd0);
    @(negedge clk);
    chk("t1_dok_c2", 64'(in_data_ok), 64'd0);
    chk("t1_req_c2", 64'(out_req), 64'd1);
    chk("t1_wr_c2", 64'(out_wr), 64'd1);
    chk("t1_addr", 64'(out_addr), 64'h1000_0040);
    chk("t1_wdata", 64'(out_wdata), 64'hDEAD_BEEF);
    chk("t1_size", 64'(out_size), 64'd2);
    @(negedge clk);
    chk("t1_req_hold", 64'(out_req), 64'd1);
    chk("t1_addr_hold", 64'(out_addr), 64'h1000_0040);
    @(posedge clk);
    #1;
    log_addr.delete();
    log_wr.delete();
    auto_en = 1'b1;
    wait_idle(50, ok);
    chk("t1_idle", 64'(ok), 64'd1);
    chk("t1_log_n", 64'(log_addr.size()), 64'd1);
    chk("t1_mem", 64'(mem[32'h1000_0040]), 64'hDEAD_BEEF);

    // 2: fill to DEPTH, fifth write stalls until first pop
    auto_en = 1'b0;
    log_addr.delete();
    log_wr.delete();
    for (int i = 0; i < 4; i++) begin
      wr(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1, w, ok);
      chk("t2_fill_aok", 64'(ok), 64'd1);
    end
    chk("t2_count4", 64'(dut.u_fifo.count_o), 64'd4);
    in_req = 1'b1;
    in_wr = 1'b1;
    in_addr = 32'h210;
    in_wdata = 32'hA4;
    repeat (3) begin
      @(negedge clk);
      chk("t2_full_stall", 64'(in_addr_ok), 64'd0);
    end
    @(posedge clk);
    #1;
    auto_en = 1'b1;
    wr(32'h210, 32'hA4, 20, w, ok);
    chk("t2_fifth_aok", 64'(ok), 64'd1);
    chk("t2_fifth_wait", 64'(w), 64'd2);
    wait_idle(100, ok);
    chk("t2_idle", 64'(ok), 64'd1);
    chk("t2_log_n", 64'(log_addr.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++)
      chk("t2_order", 64'(log_addr[i]), 64'h200 + 64'(4 * i));
    chk("t2_mem_last", 64'(mem[32'h210]), 64'hA4);

    // 3: read-after-write ordering
    dly_max = 1;
    log_addr.delete();
    log_wr.delete();
    wr(32'h100, 32'h11, 5, w, ok);
    chk("t3_wr_aok", 64'(ok), 64'd1);
    rd(32'h100, 60, w, emp, rdv, ok);
    chk("t3_rd_done", 64'(ok), 64'd1);
    chk("t3_rd_stalled", 64'(w >= 2), 64'd1);
    chk("t3_empty_at_acc", 64'(emp), 64'd1);
    chk("t3_rdata", 64'(rdv), 64'h11);
    chk("t3_log_n", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t3_first_wr", 64'(log_wr[0]), 64'd1);
      chk("t3_second_rd", 64'(log_wr[1]), 64'd0);
      chk("t3_rd_addr", 64'(log_addr[1]), 64'h100);
    end
    wait_idle(50, ok);
    chk("t3_idle", 64'(ok), 64'd1);

    // 4: drain order under random delays
    dly_max = 3;
    log_addr.delete();
    log_wr.delete();
    wr(32'h0, 32'hAAAA_0000, 10, w, ok);
    chk("t4_a_aok", 64'(ok), 64'd1);
    wr(32'h4, 32'hBBBB_0004, 10, w, ok);
    chk("t4_b_aok", 64'(ok), 64'd1);
    wr(32'h8, 32'hCCCC_0008, 10, w, ok);
    chk("t4_c_aok", 64'(ok), 64'd1);
    wait_idle(200, ok);
    chk("t4_idle", 64'(ok), 64'd1);
    chk("t4_log_n", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk("t4_order", 64'(log_addr[i]), 64'(4 * i));
      chk("t4_is_wr", 64'(log_wr[i]), 64'd1);
    end
    chk("t4_mem_b", 64'(mem[32'h4]), 64'hBBBB_0004);

    // 5: push and pop on the same edge at count 3
    auto_en = 1'b0;
    dly_max = 0;
    log_addr.delete();
    log_wr.delete();
    wr(32'h300, 32'hD0, 1, w, ok);
    wr(32'h304, 32'hD1, 1, w, ok);
    wr(32'h308, 32'hD2, 1, w, ok);
    chk("t5_count3", 64'(dut.u_fifo.count_o), 64'd3);
    chk("t5_wreq", 64'(dut.state_q), 64'(S_W_REQ));
    ma_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    ma_addr_ok = 1'b0;
    chk("t5_wwait", 64'(dut.state_q), 64'(S_W_WAIT));
    ma_data_ok = 1'b1;
    in_req = 1'b1;
    in_wr = 1'b1;
    in_addr = 32'h30C;
    in_wdata = 32'hD3;
    @(negedge clk);
    chk("t5_push_aok", 64'(in_addr_ok), 64'd1);
    @(posedge clk);
    #1;
    ma_data_ok = 1'b0;
    in_req = 1'b0;
    @(negedge clk);
    chk("t5_count_same", 64'(dut.u_fifo.count_o), 64'd3);
    chk("t5_back_wreq", 64'(dut.state_q), 64'(S_W_REQ));
    chk("t5_head_addr", 64'(out_addr), 64'h304);
    chk("t5_head_data", 64'(out_wdata), 64'hD1);
    @(posedge clk);
    #1;
    auto_en = 1'b1;
    wait_idle(100, ok);
    chk("t5_idle", 64'(ok), 64'd1);
    chk("t5_log_n", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++)
      chk("t5_order", 64'(log_addr[i]), 64'h304 + 64'(4 * i));
    chk("t5_mem_new", 64'(mem[32'h30C]), 64'hD3);

    // 6: async reset mid-drain, then a fresh write
    auto_en = 1'b0;
    log_addr.delete();
    log_wr.delete();
    wr(32'h400, 32'hE0, 1, w, ok);
    wr(32'h404, 32'hE1, 1, w, ok);
    ma_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    ma_addr_ok = 1'b0;
    wr(32'h408, 32'hE2, 1, w, ok);
    chk("t6_wwait", 64'(dut.state_q), 64'(S_W_WAIT));
    in_req = 1'b1;
    in_wr = 1'b1;
    in_addr = 32'h40C;
    #1;
    chk("t6_pre_aok", 64'(in_addr_ok), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_aok", 64'(in_addr_ok), 64'd0);
    chk("t6_rst_dok", 64'(in_data_ok), 64'd0);
    chk("t6_rst_req", 64'(out_req), 64'd0);
    chk("t6_rst_empty", 64'(dut.u_fifo.empty_o), 64'd1);
    chk("t6_rst_state", 64'(dut.state_q), 64'(S_IDLE));
    in_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    auto_en = 1'b1;
    wr(32'h500, 32'hCAFE_F00D, 5, w, ok);
    chk("t6_new_aok", 64'(ok), 64'd1);
    @(negedge clk);
    chk("t6_new_dok", 64'(in_data_ok), 64'd1);
    @(posedge clk);
    #1;
    wait_idle(50, ok);
    chk("t6_idle", 64'(ok), 64'd1);
    chk("t6_log_n", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1)
      chk("t6_log_addr", 64'(log_addr[0]), 64'h500);
    chk("t6_mem", 64'(mem[32'h500]), 64'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
